// File: rtl/cmos_pkg.sv
// cmos_pkg: shared state type and default timing for the CMOS camera bring-up blocks
package cmos_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        LOCK_FILT,
        PWDN_HOLD,
        RST_HOLD,
        INIT_WAIT,
        READY,
        FAULT
    } cmos_seq_state_t;

    localparam int PLL_RST_CYC_DEF      = 27;
    localparam int LOCK_TIMEOUT_CYC_DEF = 270000;
    localparam int LOCK_FILT_CYC_DEF    = 2700;
    localparam int PWDN_CYC_DEF         = 27000;
    localparam int RST_CYC_DEF          = 27000;
    localparam int INIT_WAIT_CYC_DEF    = 540000;
    localparam int MAX_RETRY_DEF        = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // first flop may go metastable; second gives it a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmos_power_seq.sv
// cmos_power_seq: PLL lock and CMOS sensor power/reset sequencer with SCCB init kick-off
module cmos_power_seq
    import cmos_pkg::*;
#(
    parameter int PLL_RST_CYC      = PLL_RST_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int LOCK_FILT_CYC    = LOCK_FILT_CYC_DEF,
    parameter int PWDN_CYC         = PWDN_CYC_DEF,
    parameter int RST_CYC          = RST_CYC_DEF,
    parameter int INIT_WAIT_CYC    = INIT_WAIT_CYC_DEF,
    parameter int MAX_RETRY        = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       xclk_en,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       init_start,
    output logic       seq_done,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int CNT_MAX = max2(max2(max2(PLL_RST_CYC, LOCK_TIMEOUT_CYC), max2(LOCK_FILT_CYC, PWDN_CYC)),
                                  max2(RST_CYC, INIT_WAIT_CYC));
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PLL_RST_END = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] FILT_END    = CW'(LOCK_FILT_CYC - 1);
    localparam logic [CW-1:0] PWDN_END    = CW'(PWDN_CYC - 1);
    localparam logic [CW-1:0] RST_END     = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] INIT_END    = CW'(INIT_WAIT_CYC - 1);
    localparam logic [3:0]    RETRY_LIM   = 4'(MAX_RETRY);

    cmos_seq_state_t state, state_nx;
    logic [CW-1:0]   cnt;
    logic [3:0]      retry_nx;
    logic            lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PLL_RST;
        else        state <= state_nx;
    end

    // next state and retry count; restart beats lock loss beats counter expiry
    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        if (restart) begin
            state_nx = PLL_RST;
            retry_nx = '0;
        end else begin
            case (state)
                PLL_RST:   state_nx = (cnt == PLL_RST_END) ? WAIT_LOCK : PLL_RST;
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = LOCK_FILT;
                    end else if (cnt == TIMEOUT_END) begin
                        retry_nx = retry_cnt + 4'd1;
                        state_nx = (retry_nx == RETRY_LIM) ? FAULT : PLL_RST;
                    end
                end
                LOCK_FILT: state_nx = !lock_s ? WAIT_LOCK : (cnt == FILT_END) ? PWDN_HOLD : LOCK_FILT;
                PWDN_HOLD: state_nx = !lock_s ? WAIT_LOCK : (cnt == PWDN_END) ? RST_HOLD  : PWDN_HOLD;
                RST_HOLD:  state_nx = !lock_s ? WAIT_LOCK : (cnt == RST_END)  ? INIT_WAIT : RST_HOLD;
                INIT_WAIT: state_nx = !lock_s ? WAIT_LOCK : (cnt == INIT_END) ? READY     : INIT_WAIT;
                READY:     state_nx = !lock_s ? WAIT_LOCK : READY;
                FAULT:     state_nx = FAULT;
                default:   state_nx = PLL_RST;
            endcase
        end
    end

    // shared dwell counter plus outputs registered from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            retry_cnt  <= '0;
            pll_reset  <= 1'b1;
            xclk_en    <= 1'b0;
            cmos_pwdn  <= 1'b1;
            cmos_rst_n <= 1'b0;
            init_start <= 1'b0;
            seq_done   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cnt        <= (restart || state_nx != state) ? '0 :
                          (state == READY || state == FAULT) ? cnt : cnt + CW'(1);
            retry_cnt  <= retry_nx;
            pll_reset  <= state_nx inside {PLL_RST, FAULT};
            xclk_en    <= state_nx inside {PWDN_HOLD, RST_HOLD, INIT_WAIT, READY};
            cmos_pwdn  <= !(state_nx inside {RST_HOLD, INIT_WAIT, READY});
            cmos_rst_n <= state_nx inside {INIT_WAIT, READY};
            init_start <= state_nx == READY && state != READY;
            seq_done   <= state_nx == READY;
            fault      <= state_nx == FAULT;
        end
    end

endmodule
